conv_3x3_stream_mc: RTL and testbench
=====================================

// Module: conv_3x3_stream_mc
// PURPOSE
//   Streaming, pipelined 3x3 convolution: one 9-pixel window in, CH output channels out, up to one window per cycle.
//   Generalises the fixed 4-channel combinational conv:
//     - parametric pixel, weight and output widths and channel count
//     - run-time writable weight file
//     - valid/ready backpressure
//     - per-channel overflow reporting
//   Sits between the line-buffer/window generator and the activation/pooling stage.
// PARAMETERS
//   CH     4   output channels
//   PIX_W  8   unsigned pixel width
//   W_W    8   unsigned weight width
//   OUT_W  16  per-channel result width
// PORTS
//   clk         in   1          clock, rising edge
//   rst         in   1          async, active-high reset
//   in_valid    in   1          window valid
//   in_ready    out  1          block can accept window
//   pixels_in   in   9*PIX_W    tap t at [t*PIX_W +: PIX_W], t=0..8
//   wt_we       in   1          weight write strobe
//   wt_ch       in   CHW        channel index, CHW = max(1,$clog2(CH))
//   wt_tap      in   4          tap index 0..8
//   wt_data     in   W_W        weight value
//   out_valid   out  1          result valid
//   out_ready   in   1          downstream accepts result
//   result_out  out  CH*OUT_W   channel c at [c*OUT_W +: OUT_W]
//   out_ovf     out  CH         channel c sum exceeded 2^OUT_W-1
// BEHAVIOUR
//   - Reset state:
//       - all pipeline valids 0; out_valid=0, result_out=0, out_ovf=0, in_ready=1
//       - weights W[c][t] = c+t+2 (ch0 = 2..10, ch1 = 3..11, ...)
//   - Reset mid-stream discards all in-flight windows; no partial output after release.
//   - Pipeline: S1 register 9*CH products; S2 adder tree per channel; S3 output register.
//   - Latency 3 cycles, accept to out_valid, when unstalled.
//   - Global enable en = !(out_valid && !out_ready); in_ready = en.
//     Whole pipeline holds when en=0, bubbles included; result_out stable while stalled.
//   - Accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
//     Both may occur in the same cycle. Sustained throughput 1 window/clk.
//   - Arithmetic: unsigned. Products PIX_W+W_W bits; sum ACC_W = PIX_W+W_W+4 bits, no internal loss.
//     result = sum[OUT_W-1:0] (wrap). out_ovf[c]=1 iff sum > 2^OUT_W-1.
//   - Weight write: when wt_we=1 and wt_ch<CH and wt_tap<=8, W[wt_ch][wt_tap] <= wt_data.
//     Out-of-range index: ignored, no other state changes.
//   - Writes are independent of en; they also apply while stalled.
//   - Write in the same cycle as an accept: the accepted window uses the OLD weight.
//   - Write has no effect on windows already in the pipeline.
// CONFIGURATION
//   CONV_SAT_EN defined:
//     result clamps to 2^OUT_W-1 when out_ovf[c]=1; out_ovf unchanged.
//   CONV_SAT_EN undefined:
//     wrap (low OUT_W bits); out_ovf still reported.
//   Latency and handshake are identical in both builds.
// STRUCTURE
//   - conv_pkg:
//       - TAPS=9
//       - function acc_w(pix_w, w_w)
//       - function default_weight(c, t) = c+t+2
//   - Sub-module conv_mac9:
//       - one channel: 9 multipliers, S1/S2 registers, en input, full-width sum out
//       - instantiated CH times via generate
//   - Top owns the weight file, the valid pipeline, the S3 register, and wrap/sat/ovf logic.
// TESTING (defaults CH=4, PIX_W=8, W_W=8, OUT_W=16)
//   1. Reset defaults, all pixels 1, out_ready=1
//        -> cycle+3: result_out ch0..3 = 54/63/72/81, out_ovf=0
//   2. All pixels 255
//        -> 13770/16065/18360/20655, out_ovf=0
//   3. Write W[1][4]=0 (same cycle as a pixels=1 accept), then a second pixels=1 window
//        -> first ch1=63, second ch1=56
//   4. Write all 36 weights=255, pixels=255, sum=585225
//        -> wrap build: 60937 all ch, out_ovf=4'hF
//        -> CONV_SAT_EN build: 65535 all ch, out_ovf=4'hF
//   5. Back-to-back 10 windows, out_ready low 4 cycles mid-burst
//        -> in_ready=0 while stalled, no loss or duplication, order kept
//   6. Assert rst with 2 windows in flight
//        -> out_valid=0 immediately, weights back to defaults, next window latency 3

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 streaming convolution.
package conv_pkg;

  localparam int TAPS = 9;

  // Full-precision accumulator width: product width plus 4 guard bits for 9 terms.
  function automatic int acc_w(input int pix_w, input int w_w);
    return pix_w + w_w + 4;
  endfunction

  // Power-on weight for channel c, tap t.
  function automatic int default_weight(input int c, input int t);
    return c + t + 2;
  endfunction

endpackage

// File: rtl/conv_mac9.sv
// One output channel of the 3x3 convolution.
// S1 registers the 9 products. S2 registers the full-width sum.
// Both stages advance only when en is high.
module conv_mac9
  import conv_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int ACC_W = acc_w(PIX_W, W_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [TAPS*PIX_W-1:0]   pixels,
  input  logic [TAPS*W_W-1:0]     weights,
  output logic [ACC_W-1:0]        sum
);

  localparam int PROD_W = PIX_W + W_W;

  logic [PROD_W-1:0] prod [TAPS];
  logic [ACC_W-1:0]  tree;

  // S1: register one product per tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) prod[t] <= '0;
    end else if (en) begin
      for (int t = 0; t < TAPS; t++)
        prod[t] <= PROD_W'(pixels[t*PIX_W +: PIX_W]) * PROD_W'(weights[t*W_W +: W_W]);
    end
  end

  // Adder tree over the registered products, widened so nothing is lost
  always_comb begin
    tree = '0;
    for (int t = 0; t < TAPS; t++) tree = tree + ACC_W'(prod[t]);
  end

  // S2: register the channel sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     sum <= '0;
    else if (en) sum <= tree;
  end

endmodule

// File: rtl/conv_3x3_stream_mc.sv
// Streaming, pipelined 3x3 convolution with CH output channels.
// Pipeline: S1 products, S2 channel sums (both in conv_mac9), S3 output register.
// The whole pipeline freezes while the output is held by downstream.
// Build option CONV_SAT_EN: clamp overflowing channels to all-ones instead of wrapping.
module conv_3x3_stream_mc
  import conv_pkg::*;
#(
  parameter int CH    = 4,
  parameter int PIX_W = 8,
  parameter int W_W   = 8,
  parameter int OUT_W = 16,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TAPS*PIX_W-1:0] pixels_in,
  input  logic                  wt_we,
  input  logic [CHW-1:0]        wt_ch,
  input  logic [3:0]            wt_tap,
  input  logic [W_W-1:0]        wt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   result_out,
  output logic [CH-1:0]         out_ovf
);

  localparam int ACC_W = acc_w(PIX_W, W_W);
  localparam int LIM_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [OUT_W-1:0] MAX_OUT = '1;

  logic                 en;
  logic                 v1;
  logic                 v2;
  logic [W_W-1:0]       wts [CH][TAPS];
  logic [ACC_W-1:0]     sums [CH];
  logic [CH*OUT_W-1:0]  res_next;
  logic [CH-1:0]        ovf_next;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Weight file: writes ignore en; the S1 sample at the same edge still sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++)
        for (int t = 0; t < TAPS; t++)
          wts[c][t] <= W_W'(default_weight(c, t));
    end else if (wt_we && (int'(wt_ch) < CH) && (wt_tap <= 4'd8)) begin
      wts[wt_ch][wt_tap] <= wt_data;
    end
  end

  // Valid pipeline alongside S1/S2/S3; bubbles hold with the data when stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [TAPS*W_W-1:0] wflat;

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign wflat[t*W_W +: W_W] = wts[c][t];
    end

    conv_mac9 #(
      .PIX_W (PIX_W),
      .W_W   (W_W),
      .ACC_W (ACC_W)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .pixels  (pixels_in),
      .weights (wflat),
      .sum     (sums[c])
    );
  end

  // Overflow detection and wrap/clamp of each channel sum
  always_comb begin
    res_next = '0;
    ovf_next = '0;
    for (int c = 0; c < CH; c++) begin
      ovf_next[c] = LIM_W'(sums[c]) > LIM_W'(MAX_OUT);
`ifdef CONV_SAT_EN
      res_next[c*OUT_W +: OUT_W] = ovf_next[c] ? MAX_OUT : OUT_W'(sums[c]);
`else
      res_next[c*OUT_W +: OUT_W] = OUT_W'(sums[c]);
`endif
    end
  end

  // S3: load only real windows so the output keeps the last result across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_out <= '0;
      out_ovf    <= '0;
    end else if (en && v2) begin
      result_out <= res_next;
      out_ovf    <= ovf_next;
    end
  end

endmodule

// File: tb/tb_conv_3x3_stream_mc.sv
// Randomized and directed bench for conv_3x3_stream_mc against a window-level model.
module tb_conv_3x3_stream_mc;

  localparam int CH    = 4;
  localparam int PIX_W = 8;
  localparam int W_W   = 8;
  localparam int OUT_W = 16;
  localparam int CHW   = 2;
  localparam int LIM   = (1 << OUT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [9*PIX_W-1:0]   pixels_in;
  logic                 wt_we;
  logic [CHW-1:0]       wt_ch;
  logic [3:0]           wt_tap;
  logic [W_W-1:0]       wt_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH*OUT_W-1:0]  result_out;
  logic [CH-1:0]        out_ovf;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  conv_3x3_stream_mc #(
    .CH(CH), .PIX_W(PIX_W), .W_W(W_W), .OUT_W(OUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pixels_in  (pixels_in),
    .wt_we      (wt_we),
    .wt_ch      (wt_ch),
    .wt_tap     (wt_tap),
    .wt_data    (wt_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_out (result_out),
    .out_ovf    (out_ovf)
  );

  // Model state: weight file and per-channel queue of full sums in acceptance order
  int unsigned mw [CH][9];
  int unsigned exp_q [CH][$];
  logic [CH*OUT_W-1:0] got_res_q [$];
  logic [CH-1:0]       got_ovf_q [$];
  logic                stall_prev = 1'b0;
  logic [CH*OUT_W-1:0] held_res;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int unsigned exp_res(input int unsigned s);
`ifdef CONV_SAT_EN
    return (s > LIM) ? LIM : s;
`else
    return s % (LIM + 1);
`endif
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      for (int t = 0; t < 9; t++) mw[c][t] = c + t + 2;
      exp_q[c].delete();
    end
  endfunction

  // Compare process: mid-cycle view of the handshake that the next rising edge will act on
  always @(negedge clk) begin
    if (rst) begin
      model_reset();
      stall_prev = 1'b0;
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_result_hold", result_out, held_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q[0].size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          for (int c = 0; c < CH; c++) begin
            int unsigned s;
            s = exp_q[c].pop_front();
            chk($sformatf("result_ch%0d", c), result_out[c*OUT_W +: OUT_W], exp_res(s));
            chk($sformatf("ovf_ch%0d", c), out_ovf[c], (s > LIM) ? 1 : 0);
          end
          got_res_q.push_back(result_out);
          got_ovf_q.push_back(out_ovf);
        end
      end
      if (in_valid && in_ready) begin
        for (int c = 0; c < CH; c++) begin
          int unsigned s;
          s = 0;
          for (int t = 0; t < 9; t++) s += pixels_in[t*PIX_W +: PIX_W] * mw[c][t];
          exp_q[c].push_back(s);
        end
      end
      if (wt_we && (int'(wt_ch) < CH) && (wt_tap <= 4'd8)) mw[wt_ch][wt_tap] = wt_data;
      stall_prev = out_valid && !out_ready;
      held_res   = result_out;
    end
  end

  task automatic set_pix(input int pix);
    for (int t = 0; t < 9; t++) pixels_in[t*PIX_W +: PIX_W] = pix[PIX_W-1:0];
  endtask

  // Send one uniform window and count edges until out_valid, accept edge included
  task automatic run_one(input int pix, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1;
    set_pix(pix);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_res_q.size() < n && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_outputs", (got_res_q.size() >= n) ? 1 : 0, 1);
  endtask

  int lat;
  int n0;
  int sent;
  logic [CH*OUT_W-1:0] r;

  initial begin
    rst = 1'b1; in_valid = 1'b0; pixels_in = '0; wt_we = 1'b0;
    wt_ch = '0; wt_tap = '0; wt_data = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result_out, 0);
    chk("reset_ovf", out_ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    // Default weights, unit pixels
    run_one(1, lat);
    chk("t1_latency", lat, 3);
    chk("t1_ch0", result_out[0*16 +: 16], 54);
    chk("t1_ch1", result_out[1*16 +: 16], 63);
    chk("t1_ch2", result_out[2*16 +: 16], 72);
    chk("t1_ch3", result_out[3*16 +: 16], 81);
    chk("t1_ovf", out_ovf, 0);

    // Full-scale pixels
    run_one(255, lat);
    chk("t2_latency", lat, 3);
    chk("t2_ch0", result_out[0*16 +: 16], 13770);
    chk("t2_ch1", result_out[1*16 +: 16], 16065);
    chk("t2_ch2", result_out[2*16 +: 16], 18360);
    chk("t2_ch3", result_out[3*16 +: 16], 20655);
    chk("t2_ovf", out_ovf, 0);
    repeat (4) @(posedge clk);
    #1;

    // Weight write coinciding with an accept, then a second window
    n0 = got_res_q.size();
    in_valid = 1'b1; set_pix(1);
    wt_we = 1'b1; wt_ch = 2'd1; wt_tap = 4'd4; wt_data = 8'd0;
    @(posedge clk); #1;
    wt_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_got(n0 + 2);
    r = got_res_q[n0];
    chk("t3_first_ch1", r[16 +: 16], 63);
    r = got_res_q[n0 + 1];
    chk("t3_second_ch1", r[16 +: 16], 56);

    // All weights full scale: every channel overflows
    for (int c = 0; c < CH; c++) begin
      for (int t = 0; t < 9; t++) begin
        wt_we = 1'b1; wt_ch = c[CHW-1:0]; wt_tap = t[3:0]; wt_data = 8'd255;
        @(posedge clk); #1;
      end
    end
    wt_we = 1'b0;
    run_one(255, lat);
    chk("t4_latency", lat, 3);
    for (int c = 0; c < CH; c++) begin
`ifdef CONV_SAT_EN
      chk($sformatf("t4_ch%0d", c), result_out[c*16 +: 16], 65535);
`else
      chk($sformatf("t4_ch%0d", c), result_out[c*16 +: 16], 60937);
`endif
    end
    chk("t4_ovf", out_ovf, 4'hF);
    repeat (4) @(posedge clk);
    #1;

    // Burst of 10 windows with downstream stalled for 4 cycles mid-burst
    n0 = got_res_q.size();
    sent = 0;
    set_pix($urandom);
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (sent < 10);
      #1;
      if (cyc >= 5 && cyc < 8) chk("t5_in_ready_stalled", in_ready, 0);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      for (int t = 0; t < 9; t++) pixels_in[t*PIX_W +: PIX_W] = 8'($urandom);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_got(n0 + 10);
    chk("t5_no_dup", got_res_q.size(), n0 + 10);

    // Random traffic with random stalls and weight writes, including out-of-range taps
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int t = 0; t < 9; t++) pixels_in[t*PIX_W +: PIX_W] = 8'($urandom);
      wt_we   = ($urandom_range(0, 9) == 0);
      wt_ch   = CHW'($urandom);
      wt_tap  = 4'($urandom_range(0, 15));
      wt_data = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; wt_we = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("drain_empty", exp_q[0].size(), 0);

    // Reset with two windows in flight
    in_valid = 1'b1; set_pix(1);
    @(posedge clk); #1;
    set_pix(2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_out_valid_in_reset", out_valid, 0);
    n0 = got_res_q.size();
    @(posedge clk); #1;
    rst = 1'b0;
    run_one(1, lat);
    chk("t6_latency", lat, 3);
    chk("t6_ch0", result_out[0*16 +: 16], 54);
    chk("t6_ch3", result_out[3*16 +: 16], 81);
    @(posedge clk); #1;
    chk("t6_no_stale_output", got_res_q.size(), n0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
